serial_addsub_16bits: RTL



---
 rtl/serial_addsub_16bits.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/serial_addsub_16bits.sv
// Multi-cycle 16-bit adder/subtractor: one SLICE_W-bit ripple slice per clock, carry held in a flop.
// Optional signed-overflow output enabled by defining ADDSUB_OVF_EN; otherwise ovf is tied low.
module serial_addsub_16bits #(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic        cout,
  output logic        ovf
);

  localparam int NSLICE = 16 / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 || SLICE_W == 8 || SLICE_W == 16)) begin : g_bad_slice_w
      $error("serial_addsub_16bits: SLICE_W must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sub_q, sub_d;
  logic [15:0]        out_q, out_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W:0]   slice_sum;
  logic               last_slice;

  // Slice select is a compare-per-slice mux so every part select has a constant base.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_slice = a_q[i*SLICE_W +: SLICE_W];
        b_slice = b_q[i*SLICE_W +: SLICE_W];
      end
    end
    slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry_q};
    last_slice = (idx_q == IDX_W'(NSLICE - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    out_d   = out_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is A + ~B + ~borrow_in, so the adder slice never changes.
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          carry_d = sub ? ~cin : cin;
          sub_d   = sub;
          idx_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDX_W'(i)) begin
            out_d[i*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
          end
        end
        carry_d = slice_sum[SLICE_W];
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) begin
          cout_d  = sub_q ? ~slice_sum[SLICE_W] : slice_sum[SLICE_W];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow uses the effective B (already inverted for subtract) and the final sign bit.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      ovf_d = 1'b0;
    end else if (state_q == RUN && last_slice) begin
      ovf_d = (a_q[15] == b_q[15]) && (out_d[15] != a_q[15]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign out  = out_q;
  assign cout = cout_q;

endmodule
